// File: rtl/s27_bist_pkg.sv
// rtl/s27_bist_pkg.sv - shared constants and state encoding for the s27 BIST controller
package s27_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } bist_state_e;

   localparam logic [3:0] LFSR_SEED        = 4'b0001;
   localparam logic [3:0] LFSR_TAPS        = 4'b1100;
   localparam logic [3:0] FLUSH_PATTERN    = 4'b1100;
   localparam logic [7:0] SIG_POLY_DEFAULT = 8'h1D;

endpackage

// File: rtl/bist_lfsr4.sv
// rtl/bist_lfsr4.sv - 4-bit Fibonacci LFSR pattern source with load and step enables
module bist_lfsr4
   import s27_bist_pkg::*;
(
   input  logic       CK,
   input  logic       RST,
   input  logic       load,
   input  logic       step,
   output logic [3:0] q
);

   logic fb;

   assign fb = ^(q & LFSR_TAPS);

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         q <= LFSR_SEED;
      end else if (load) begin
         q <= LFSR_SEED;
      end else if (step) begin
         q <= {q[2:0], fb};
      end
   end

endmodule

// File: rtl/s27_bist_ctrl.sv
// rtl/s27_bist_ctrl.sv - BIST controller: input mux, flush, LFSR patterns and SISR compaction for s27
// Optional registered signature comparator and pass output under S27_BIST_COMPARE_EN.
module s27_bist_ctrl
   import s27_bist_pkg::*;
#(
   parameter int               N_PATTERNS   = 15,
   parameter int               FLUSH_CYCLES = 3,
   parameter int               SIG_W        = 8,
   parameter logic [SIG_W-1:0] SIG_POLY     = SIG_W'(SIG_POLY_DEFAULT)
`ifdef S27_BIST_COMPARE_EN
   ,
   parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
`endif
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             start,
   input  logic [3:0]       func_g,
   output logic             G0,
   output logic             G1,
   output logic             G2,
   output logic             G3,
   input  logic             G17,
   output logic             busy,
   output logic             done,
   output logic [SIG_W-1:0] signature
`ifdef S27_BIST_COMPARE_EN
   ,
   output logic             pass
`endif
);

   localparam logic [1:0] IDLE  = ST_IDLE;
   localparam logic [1:0] FLUSH = ST_FLUSH;
   localparam logic [1:0] RUN   = ST_RUN;
   localparam logic [1:0] DONE  = ST_DONE;

   localparam int FLUSH_W = $clog2(FLUSH_CYCLES);

   logic [1:0]         state;
   logic [FLUSH_W-1:0] flush_cnt;
   logic [3:0]         run_cnt;
   logic [3:0]         lfsr_q;
   logic [3:0]         g_mux;
   logic [SIG_W-1:0]   sig_next;
   logic               fb_bit;
   logic               accept;
   logic               last_run;

   assign accept   = (state == IDLE) && start;
   assign last_run = (state == RUN) && (run_cnt == '0);

   bist_lfsr4 u_lfsr (
      .CK   (CK),
      .RST  (RST),
      .load (accept),
      .step (state == RUN),
      .q    (lfsr_q)
   );

   // Serial-input signature register: shift in G17 with polynomial feedback.
   always_comb begin
      fb_bit   = signature[SIG_W-1] ^ G17;
      sig_next = {signature[SIG_W-2:0], 1'b0} ^ (fb_bit ? SIG_POLY : '0);
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         flush_cnt <= '0;
         run_cnt   <= '0;
         signature <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= FLUSH;
                  flush_cnt <= FLUSH_W'(FLUSH_CYCLES - 1);
                  signature <= '0;
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  state   <= RUN;
                  run_cnt <= 4'(N_PATTERNS - 1);
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            RUN: begin
               signature <= sig_next;
               if (run_cnt == '0) begin
                  state <= DONE;
               end else begin
                  run_cnt <= run_cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef S27_BIST_COMPARE_EN
   // Verdict is taken from the signature being written on the final RUN edge.
   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         pass <= 1'b0;
      end else if (accept) begin
         pass <= 1'b0;
      end else if (last_run) begin
         pass <= (sig_next == GOLDEN_SIG);
      end
   end
`endif

   always_comb begin
      g_mux = func_g;
      case (state)
         FLUSH:   g_mux = FLUSH_PATTERN;
         RUN:     g_mux = lfsr_q;
         default: g_mux = func_g;
      endcase
   end

   assign {G3, G2, G1, G0} = g_mux;
   assign busy             = (state == FLUSH) || (state == RUN);
   assign done             = (state == DONE);

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// tb/tb_s27_bist_ctrl.sv - randomized bench for s27_bist_ctrl with an s27 core and signature reference model
module tb_s27_bist_ctrl;

   localparam int         NP   = 15;
   localparam int         FC   = 3;
   localparam logic [7:0] POLY = 8'h1D;

   localparam logic [3:0] PAT_SEQ [15] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                          4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8};

   localparam int M_CORE = 0;
   localparam int M_RAND = 1;
   localparam int M_FLIP = 2;
   localparam int M_ZERO = 3;
   localparam int M_ONE1 = 4;

   logic       CK = 1'b0;
   logic       RST;
   logic       start;
   logic [3:0] func_g;
   logic       G0, G1, G2, G3;
   logic       G17;
   logic       busy;
   logic       done;
   logic [7:0] signature;
`ifdef S27_BIST_COMPARE_EN
   logic       pass;
`endif

   int vectors     = 0;
   int miscompares = 0;

   int         mode      = M_ZERO;
   logic       drive_bit = 1'b0;
   logic       flip_now  = 1'b0;
   logic [2:0] cst       = 3'b101;
   logic [3:0] core_r;
   logic [3:0] g_bus;
   logic       exp_bits [15];
   logic [7:0] exp_sig;

   always #5 CK = ~CK;

   s27_bist_ctrl dut (
      .CK        (CK),
      .RST       (RST),
      .start     (start),
      .func_g    (func_g),
      .G0        (G0),
      .G1        (G1),
      .G2        (G2),
      .G3        (G3),
      .G17       (G17),
      .busy      (busy),
      .done      (done),
      .signature (signature)
`ifdef S27_BIST_COMPARE_EN
      ,
      .pass      (pass)
`endif
   );

   // ISCAS s27: returns {G13, G11, G10, G17}; next state {G7,G6,G5} = {G13,G11,G10}.
   function automatic logic [3:0] s27_step(input logic [3:0] g, input logic [2:0] st);
      logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
      g5  = st[0];
      g6  = st[1];
      g7  = st[2];
      g14 = ~g[0];
      g12 = ~(g[1] | g7);
      g13 = ~(g[2] | g12);
      g8  = g14 & g6;
      g15 = g12 | g8;
      g16 = g[3] | g8;
      g9  = ~(g16 & g15);
      g11 = ~(g5 | g9);
      g10 = ~(g14 | g11);
      return {g13, g11, g10, ~g11};
   endfunction

   assign g_bus = {G3, G2, G1, G0};
   always_comb core_r = s27_step(g_bus, cst);
   always_comb G17 = (mode == M_CORE || mode == M_FLIP) ? (core_r[0] ^ flip_now) : drive_bit;
   always @(posedge CK) cst <= core_r[3:1];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic build_model(input int m, input int flip_idx);
      logic [2:0] st;
      logic [3:0] r;
      logic       f;
      st      = 3'b010;
      exp_sig = 8'h00;
      for (int i = 0; i < NP; i++) begin
         r = s27_step(PAT_SEQ[i], st);
         st = r[3:1];
         case (m)
            M_CORE:  exp_bits[i] = r[0];
            M_FLIP:  exp_bits[i] = r[0] ^ (i == flip_idx);
            M_RAND:  exp_bits[i] = 1'($urandom);
            M_ONE1:  exp_bits[i] = (i == 0);
            default: exp_bits[i] = 1'b0;
         endcase
         f = exp_sig[7] ^ exp_bits[i];
         exp_sig = (exp_sig << 1) ^ (f ? POLY : 8'h00);
      end
   endtask

   task automatic run_test(input int m, input bit do_abort);
      int         flip_idx;
      logic [3:0] exp_g;
      flip_idx = $urandom_range(0, NP - 1);
      build_model(m, flip_idx);
      mode     = m;
      flip_now = 1'b0;
      start    = 1'b1;
      @(posedge CK);
      #1;
      for (int c = 1; c <= FC + NP + 1; c++) begin
         func_g = 4'($urandom);
         start  = 1'($urandom);
         if (c > FC && c <= FC + NP) begin
            drive_bit = exp_bits[c - FC - 1];
            flip_now  = (m == M_FLIP) && (c - FC - 1 == flip_idx);
         end else begin
            drive_bit = 1'b0;
            flip_now  = 1'b0;
         end
         #1;
         if (c <= FC) exp_g = 4'b1100;
         else if (c <= FC + NP) exp_g = PAT_SEQ[c - FC - 1];
         else exp_g = func_g;
         check($sformatf("g_c%0d", c), 32'(g_bus), 32'(exp_g));
         check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= FC + NP));
         check($sformatf("done_c%0d", c), 32'(done), 32'(c == FC + NP + 1));
         if (c == 1) begin
            check("sig_cleared", 32'(signature), 32'h0);
`ifdef S27_BIST_COMPARE_EN
            check("pass_cleared", 32'(pass), 32'h0);
`endif
         end
         if (do_abort && c == FC + 5) begin
            start = 1'b0;
            RST   = 1'b1;
            #1;
            check("abort_busy", 32'(busy), 32'h0);
            check("abort_sig", 32'(signature), 32'h0);
            check("abort_done", 32'(done), 32'h0);
            check("abort_g", 32'(g_bus), 32'(func_g));
            @(posedge CK);
            #1;
            RST = 1'b0;
            #1;
            check("post_abort_busy", 32'(busy), 32'h0);
            check("post_abort_g", 32'(g_bus), 32'(func_g));
            return;
         end
         if (c == FC + NP + 1) begin
            check($sformatf("sig_mode%0d", m), 32'(signature), 32'(exp_sig));
`ifdef S27_BIST_COMPARE_EN
            check("pass_done", 32'(pass), 32'(exp_sig == 8'h00));
`endif
         end
         @(posedge CK);
         #1;
      end
      start = 1'b0;
      #1;
      check("sig_hold", 32'(signature), 32'(exp_sig));
      check("done_low", 32'(done), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
`ifdef S27_BIST_COMPARE_EN
      check("pass_hold", 32'(pass), 32'(exp_sig == 8'h00));
`endif
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         func_g = 4'($urandom);
         #1;
         check("idle_passthru", 32'(g_bus), 32'(func_g));
         @(posedge CK);
         #1;
      end
   endtask

   initial begin
      RST    = 1'b1;
      start  = 1'b0;
      func_g = 4'b1010;
      repeat (2) @(posedge CK);
      #1;
      check("rst_g", 32'(g_bus), 32'hA);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_sig", 32'(signature), 32'h0);
`ifdef S27_BIST_COMPARE_EN
      check("rst_pass", 32'(pass), 32'h0);
`endif
      RST = 1'b0;
      @(posedge CK);
      #1;
      check("idle_g", 32'(g_bus), 32'hA);
      check("idle_sig", 32'(signature), 32'h0);

      run_test(M_CORE, 1'b0);
      run_test(M_CORE, 1'b0);
      run_test(M_ZERO, 1'b0);
      check("zero_sig", 32'(signature), 32'h0);
      idle_cycles(2);
      run_test(M_ONE1, 1'b0);
      run_test(M_CORE, 1'b1);
      idle_cycles(1);
      run_test(M_CORE, 1'b0);
      for (int t = 0; t < 10; t++) begin
         run_test($urandom_range(0, 2), 1'b0);
         idle_cycles($urandom_range(0, 3));
      end
      run_test(M_FLIP, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/s27_bist_ctrl.md
# s27_bist_ctrl

Built-in self-test controller sitting directly upstream of the s27 benchmark core on the same clock. It muxes the core's G0–G3 inputs between functional drivers and an on-chip 4-bit LFSR, flushes the core's uninitialised flip-flops to a known state, applies a pseudo-random pattern sequence, and compacts the returned G17 stream into a serial signature register. It runs one self-test per `start` pulse and otherwise passes functional inputs through transparently.

## Interface
- `N_PATTERNS`, 15: RUN-phase cycles; 1..15.
- `FLUSH_CYCLES`, 3: flush cycles before RUN; ≥2.
- `SIG_W`, 8: signature width; ≥4.
- `SIG_POLY`, 8'h1D: SISR feedback taps (x^8+x^4+x^3+x^2+1 at default).
- `GOLDEN_SIG`, 8'h00: expected signature; used only with the compare feature.
- `CK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `start` in 1: begin self-test; sampled in IDLE only.
- `func_g` in 4: functional values for G3..G0.
- `G0`, `G1`, `G2`, `G3` out 1 each: drive the core inputs.
- `G17` in 1: core output.
- `busy` out 1: high in FLUSH and RUN.
- `done` out 1: one-cycle pulse on test completion.
- `signature` out SIG_W: compacted response.
- `pass` out 1: present only with `S27_BIST_COMPARE_EN`.

## Operation
- FSM states: IDLE, FLUSH, RUN, DONE. Reset state: IDLE.
- IDLE: `{G3,G2,G1,G0}` = `func_g`, combinational pass-through. `start`=1 → FLUSH; clear `signature` to 0; load flush counter; seed LFSR to 4'b0001.
- FLUSH: drive `{G3,G2,G1,G0}` = 4'b1100. This forces the core state to G5=0, G7=0, G6=1 within 2 cycles. After `FLUSH_CYCLES` cycles → RUN.
- RUN: drive `{G3,G2,G1,G0}` = LFSR value q.
  - LFSR update per cycle: fb = q[3]^q[2]; q ← {q[2:0], fb}.
  - Sequence from seed: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8; period 15.
  - On each RUN edge, G17 is captured into the SISR: f = sig[SIG_W-1]^G17; sig ← (sig<<1) ^ (f ? SIG_POLY : 0). Bit 0 of SIG_POLY must be 1.
  - After `N_PATTERNS` captures → DONE.
- DONE: drive `func_g`; `done`=1 for this single cycle; → IDLE. `signature` holds until the next `start`.
- `start` during FLUSH, RUN or DONE is ignored. `func_g` is ignored while `busy` or in DONE.
- `RST` mid-test: abort immediately; return to IDLE and reset all outputs.
- Reset values: `busy`=0, `done`=0, `signature`=0, `pass`=0, LFSR=4'b0001. G0..G3 follow `func_g` (IDLE pass-through).

## Timing
- `start` high at edge k → FLUSH from cycle k+1; `busy` high from k+1.
- RUN occupies cycles k+1+FLUSH_CYCLES through k+FLUSH_CYCLES+N_PATTERNS.
- G17 is combinational in the current pattern and core state, so it is sampled at the edge ending each RUN cycle. There is no pipeline offset.
- `done` is high in cycle k+1+FLUSH_CYCLES+N_PATTERNS; `busy` is low in that cycle.
- `signature` is final from the same cycle and stable afterwards.
- Back-to-back: `start` may be accepted in the cycle immediately after DONE.
- Defaults: 3 + 15 = 18 busy cycles; `done` at k+19.

## Configuration
- `S27_BIST_COMPARE_EN` defined:
  - Adds `pass` output and a registered comparator.
  - On entry to DONE, `pass` ← (final signature == GOLDEN_SIG).
  - `pass` holds until the next `start`, which clears it to 0.
- Macro undefined: no `pass` port, no comparator. All other behaviour is identical.

## Structure
- Package `s27_bist_pkg`:
  - FSM state enum (IDLE, FLUSH, RUN, DONE).
  - LFSR seed 4'b0001 and taps (bits 3, 2).
  - Flush pattern 4'b1100.
  - Default SIG_POLY.
- Sub-module `bist_lfsr4`: 4-bit Fibonacci LFSR with `load` and `step` enables, seeded from the package.
- FSM, counters, SISR, input mux and comparator live in `s27_bist_ctrl`.

## Test plan
- Reset then idle, `func_g`=4'b1010 → G3..G0 = 1,0,1,0; `busy`=0, `signature`=0.
- Start at edge k, G17 observed → G=4'b1100 for cycles k+1..k+3. G then steps 1,2,4,…,8 for 15 cycles. `done` pulses at k+19.
- Full run against the s27 core → `signature` matches the bit-accurate model of the core plus the SISR. Repeating the run gives an identical signature.
- Tie G17=0 → signature 0. Tie G17=1 for 1 cycle → signature = SIG_POLY shifted per the model.
- Assert `RST` at RUN cycle 5 → next cycle IDLE, `busy`=0, `signature`=0, G follows `func_g`. A later `start` runs a clean full test.
- With `S27_BIST_COMPARE_EN`: GOLDEN_SIG = model value → `pass`=1. Inject one flipped G17 bit → `pass`=0. `start` again → `pass` clears to 0.
